spi_xfer_scheduler: RTL and testbench

Round-robin scheduler that shares one SPI master (mode 0, byte-serial, clocked by a strobe) between `NREQ` requesters. Generates the `SCLK_PULSE` strobe, grants one requester at a time, feeds its TX bytes to the master, returns RX bytes, and frames each multi-byte transfer with chip-select hold and inter-transfer gap. Sits between client logic and the SPI master, in the master's clock domain.

---
 rtl/spi_sched_pkg.sv | 32 +++
 rtl/spi_clk_pulse_gen.sv | 27 ++
 rtl/spi_xfer_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_spi_xfer_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types, defaults and the round-robin picker for the SPI transfer scheduler.
package spi_sched_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StGap  = 2'd2
    } state_e;

    localparam int unsigned DEF_DIV        = 8;
    localparam int unsigned DEF_GAP_PULSES = 2;
    localparam int unsigned DEF_TIMEOUT    = 64;

    // First set bit of req at or after ptr, wrapping modulo nreq (nreq <= 4).
    function automatic logic [1:0] rr_select(input logic [3:0] req, input logic [1:0] ptr,
                                             input int unsigned nreq);
        logic [1:0]  w_sel;
        logic        w_found;
        int unsigned w_idx;
        w_sel   = ptr;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = ({30'd0, ptr} + i) % nreq;
            if (!w_found && (i < nreq) && req[w_idx[1:0]]) begin
                w_sel   = w_idx[1:0];
                w_found = 1'b1;
            end
        end
        return w_sel;
    endfunction

endpackage

// File: rtl/spi_clk_pulse_gen.sv
// Free-running divider producing a one-cycle SCLK strobe every DIV clocks.
module spi_clk_pulse_gen
    import spi_sched_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic CTRL_CLK,
    input  logic RST,
    output logic SCLK_PULSE
);
    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CTRL_CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign SCLK_PULSE = (r_cnt == CW'(DIV - 1));

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin scheduler sharing one byte-serial SPI master between NREQ requesters,
// with per-byte timeout and chip-select gap between transfers.
module spi_xfer_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned LW         = 4,
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned GAP_PULSES = DEF_GAP_PULSES,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               CTRL_CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*LW-1:0] REQ_LEN,
    input  logic [NREQ*8-1:0]  TX_DATA,
    output logic [NREQ-1:0]    GNT,
    output logic               TX_READY,
    output logic [7:0]         RX_DATA,
    output logic               RX_VALID,
    output logic               DONE,
    output logic               ERR,
    output logic               BUSY,
    output logic               SCLK_PULSE,
    output logic               SPI_EN_N,
    output logic [7:0]         SPI_TX_BYTE,
    input  logic [7:0]         SPI_RX_BYTE,
    input  logic [7:0]         SPI_PTR
);
    localparam int unsigned RW = LW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = $clog2(GAP_PULSES + 1);

    state_e          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [1:0]      r_win, w_win_nxt, r_rr_ptr, w_rr_nxt, w_sel;
    logic [RW-1:0]   r_rem, w_rem_nxt, w_len_sel;
    logic [LW-1:0]   w_len_field;
    logic [7:0]      r_ptr_last, w_ptr_nxt, r_tx_byte, w_tx_nxt, r_rx_data, w_rx_nxt;
    logic            r_tx_ready, w_tx_ready_nxt, r_rx_valid, w_rx_valid_nxt;
    logic            r_done, w_done_nxt, r_err_pulse, w_err_pulse_nxt;
    logic            r_err, w_err_nxt, r_en_n, w_en_n_nxt;
    logic [TW-1:0]   r_to_cnt, w_to_nxt;
    logic [GW-1:0]   r_gap_cnt, w_gap_nxt;
    logic [3:0]      w_req4;
    logic            w_strobe;

    spi_clk_pulse_gen #(
        .DIV(DIV)
    ) u_pulse (
        .CTRL_CLK  (CTRL_CLK),
        .RST       (RST),
        .SCLK_PULSE(w_strobe)
    );

    always_comb begin
        w_req4           = '0;
        w_req4[NREQ-1:0] = REQ;
        w_sel            = rr_select(w_req4, r_rr_ptr, NREQ);
        w_len_field      = REQ_LEN[w_sel*LW +: LW];
        // A zero length field encodes the maximum, 2^LW bytes.
        w_len_sel = (w_len_field == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, w_len_field};
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_win_nxt       = r_win;
        w_rr_nxt        = r_rr_ptr;
        w_rem_nxt       = r_rem;
        w_ptr_nxt       = r_ptr_last;
        w_tx_nxt        = r_tx_byte;
        w_rx_nxt        = r_rx_data;
        w_tx_ready_nxt  = 1'b0;
        w_rx_valid_nxt  = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_pulse_nxt = 1'b0;
        w_err_nxt       = r_err;
        w_en_n_nxt      = 1'b1;
        w_to_nxt        = r_to_cnt;
        w_gap_nxt       = r_gap_cnt;
        unique case (r_state)
            StIdle: begin
                if (|REQ) begin
                    w_win_nxt      = w_sel;
                    w_gnt_nxt      = NREQ'(1) << w_sel;
                    w_rem_nxt      = w_len_sel;
                    w_tx_nxt       = TX_DATA[w_sel*8 +: 8];
                    w_tx_ready_nxt = 1'b1;
                    w_ptr_nxt      = SPI_PTR;
                    w_to_nxt       = '0;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = StRun;
                end
            end
            StRun: begin
                w_en_n_nxt = 1'b0;
                if (SPI_PTR != r_ptr_last) begin
                    w_rx_nxt       = SPI_RX_BYTE;
                    w_rx_valid_nxt = 1'b1;
                    w_ptr_nxt      = SPI_PTR;
                    w_rem_nxt      = r_rem - RW'(1);
                    w_to_nxt       = '0;
                    if (r_rem > RW'(1)) begin
                        w_tx_nxt       = TX_DATA[r_win*8 +: 8];
                        w_tx_ready_nxt = 1'b1;
                    end else begin
                        w_en_n_nxt  = 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = StGap;
                    end
                end else if (w_strobe) begin
                    if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                        w_err_nxt   = 1'b1;
                        w_en_n_nxt  = 1'b1;
                        w_gap_nxt   = '0;
                        w_state_nxt = StGap;
                    end else begin
                        w_to_nxt = r_to_cnt + TW'(1);
                    end
                end
            end
            StGap: begin
                // DONE goes out with GNT still set; the grant is released one cycle later.
                if (r_done) begin
                    w_gnt_nxt   = '0;
                    w_rr_nxt    = (r_win == 2'(NREQ - 1)) ? 2'd0 : r_win + 2'd1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = StIdle;
                end else if (w_strobe) begin
                    if (r_gap_cnt == GW'(GAP_PULSES - 1)) begin
                        w_done_nxt      = 1'b1;
                        w_err_pulse_nxt = r_err;
                    end else begin
                        w_gap_nxt = r_gap_cnt + GW'(1);
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge CTRL_CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_gnt       <= '0;
            r_win       <= '0;
            r_rr_ptr    <= '0;
            r_rem       <= '0;
            r_ptr_last  <= '0;
            r_tx_byte   <= '0;
            r_rx_data   <= '0;
            r_tx_ready  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err       <= 1'b0;
            r_en_n      <= 1'b1;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_win       <= w_win_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_rem       <= w_rem_nxt;
            r_ptr_last  <= w_ptr_nxt;
            r_tx_byte   <= w_tx_nxt;
            r_rx_data   <= w_rx_nxt;
            r_tx_ready  <= w_tx_ready_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_done      <= w_done_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err       <= w_err_nxt;
            r_en_n      <= w_en_n_nxt;
            r_to_cnt    <= w_to_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    assign GNT         = r_gnt;
    assign TX_READY    = r_tx_ready;
    assign RX_DATA     = r_rx_data;
    assign RX_VALID    = r_rx_valid;
    assign DONE        = r_done;
    assign ERR         = r_err_pulse;
    assign BUSY        = (r_state != StIdle);
    assign SCLK_PULSE  = w_strobe;
    assign SPI_EN_N    = r_en_n;
    assign SPI_TX_BYTE = r_tx_byte;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Bench for spi_xfer_scheduler: byte-level SPI slave model returning ~MOSI, RX/DONE scoreboard.
module tb_spi_xfer_scheduler;
    localparam int unsigned NREQ = 2;
    localparam int unsigned LW   = 4;
    localparam int unsigned DIV  = 8;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TO   = 64;

    logic               CTRL_CLK = 1'b0;
    logic               RST = 1'b1;
    logic [NREQ-1:0]    REQ = '0;
    logic [NREQ*LW-1:0] REQ_LEN = '0;
    logic [NREQ*8-1:0]  TX_DATA = '0;
    logic [NREQ-1:0]    GNT;
    logic               TX_READY, RX_VALID, DONE, ERR, BUSY, SCLK_PULSE, SPI_EN_N;
    logic [7:0]         RX_DATA, SPI_TX_BYTE;
    logic [7:0]         SPI_RX_BYTE = '0;
    logic [7:0]         SPI_PTR = '0;

    spi_xfer_scheduler #(
        .NREQ(NREQ), .LW(LW), .DIV(DIV), .GAP_PULSES(GAP), .TIMEOUT(TO)
    ) dut (
        .CTRL_CLK(CTRL_CLK), .RST(RST), .REQ(REQ), .REQ_LEN(REQ_LEN), .TX_DATA(TX_DATA),
        .GNT(GNT), .TX_READY(TX_READY), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY), .SCLK_PULSE(SCLK_PULSE), .SPI_EN_N(SPI_EN_N),
        .SPI_TX_BYTE(SPI_TX_BYTE), .SPI_RX_BYTE(SPI_RX_BYTE), .SPI_PTR(SPI_PTR)
    );

    always #5 CTRL_CLK = ~CTRL_CLK;

    typedef struct {
        int unsigned rq;
        logic [3:0]  len;
        logic [7:0]  b0;
        logic [7:0]  step;
        logic        preset;
    } vec_t;

    vec_t            vecs [5];
    int              errors = 0;
    int              checks = 0;
    logic [7:0]      tx_mem [NREQ][32];
    int unsigned     tx_idx [NREQ];
    logic [7:0]      exp_rx [$];
    logic [NREQ:0]   exp_done [$];
    int unsigned     n_txr = 0, n_rxv = 0, n_done = 0;
    int unsigned     gap_strobes = 0, en_low_strobes = 0, gnt_bad = 0;
    logic            p_txr = 0, p_rxv = 0, p_done = 0, p_err = 0;
    logic            watch_en = 0;
    logic [NREQ-1:0] watch_gnt = '0;
    int unsigned     bitcnt = 0;
    logic [7:0]      shreg = '0;
    logic            stall = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int unsigned act, input int unsigned lo,
                           input int unsigned hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic mon_step();
        logic [NREQ:0] e;
        logic [7:0]    r;
        if (TX_READY) begin
            chk_eq("tx_ready_width", 32'(p_txr), 0);
            chk_eq("tx_ready_onehot_gnt", 32'($onehot(GNT)), 1);
            n_txr++;
            for (int i = 0; i < NREQ; i++) if (GNT[i]) tx_idx[i]++;
        end
        if (RX_VALID) begin
            chk_eq("rx_valid_width", 32'(p_rxv), 0);
            n_rxv++;
            chk_eq("rx_expected", 32'(exp_rx.size() > 0), 1);
            if (exp_rx.size() > 0) begin
                r = exp_rx.pop_front();
                chk_eq("rx_data", 32'(RX_DATA), 32'(r));
            end
        end
        if (DONE) begin
            chk_eq("done_width", 32'(p_done), 0);
            n_done++;
            chk_eq("done_expected", 32'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) begin
                e = exp_done.pop_front();
                chk_eq("done_gnt", 32'(GNT), 32'(e[NREQ-1:0]));
                chk_eq("done_err", 32'(ERR), 32'(e[NREQ]));
            end
            chk_eq("gap_strobes", gap_strobes, GAP);
            chk_eq("done_en_n", 32'(SPI_EN_N), 1);
        end
        if (ERR) begin
            chk_eq("err_width", 32'(p_err), 0);
            chk_eq("err_with_done", 32'(DONE), 1);
        end
        if (!SPI_EN_N) gap_strobes = 0;
        else if (SCLK_PULSE) gap_strobes++;
        if (!SPI_EN_N && SCLK_PULSE) en_low_strobes++;
        if (watch_en && BUSY && GNT != watch_gnt) gnt_bad++;
        p_txr  = TX_READY;
        p_rxv  = RX_VALID;
        p_done = DONE;
        p_err  = ERR;
    endtask

    // Slave side of the master: 8 strobes per byte, returns the inverted MOSI byte.
    task automatic model_step();
        if (SPI_EN_N) begin
            bitcnt = 0;
        end else if (SCLK_PULSE && !stall) begin
            if (bitcnt == 0) shreg = SPI_TX_BYTE;
            if (bitcnt == 7) begin
                SPI_RX_BYTE = ~shreg;
                SPI_PTR     = SPI_PTR + 8'd1;
                bitcnt      = 0;
            end else begin
                bitcnt++;
            end
        end
    endtask

    task automatic drive_tx();
        for (int r = 0; r < NREQ; r++) TX_DATA[r*8 +: 8] = tx_mem[r][tx_idx[r] % 32];
    endtask

    task automatic tick();
        @(negedge CTRL_CLK);
        mon_step();
        model_step();
        drive_tx();
    endtask

    task automatic setup_req(input int unsigned r, input logic [3:0] len, input logic [7:0] b0,
                             input logic [7:0] step, input bit push);
        logic [7:0]  v;
        int unsigned n;
        n = (len == 4'd0) ? 16 : int'(len);
        v = b0;
        for (int i = 0; i < 32; i++) begin
            tx_mem[r][i] = v;
            v            = v + step;
        end
        tx_idx[r]          = 0;
        REQ_LEN[r*LW +: LW] = len;
        if (push) for (int i = 0; i < int'(n); i++) exp_rx.push_back(~tx_mem[r][i]);
        drive_tx();
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned d0;
        bit          seen;
        d0   = n_done;
        seen = 0;
        for (int k = 0; k < int'(budget) && !seen; k++) begin
            tick();
            if (n_done != d0) seen = 1;
        end
        if (!seen) chk_eq("done_timeout", n_done, d0 + 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = !BUSY;
        for (int k = 0; k < 200 && !idle; k++) begin
            tick();
            idle = !BUSY;
        end
        if (!idle) chk_eq("idle_timeout", 32'(BUSY), 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [NREQ-1:0] oh;
        int unsigned     n, t0, r0;
        n      = (v.len == 4'd0) ? 16 : int'(v.len);
        oh     = '0;
        oh[v.rq] = 1'b1;
        wait_idle();
        setup_req(v.rq, v.len, v.b0, v.step, 1);
        if (v.preset) SPI_PTR = 8'hFF;
        exp_done.push_back({1'b0, oh});
        t0 = n_txr;
        r0 = n_rxv;
        REQ = oh;
        tick();
        chk_eq("grant_gnt", 32'(GNT), 32'(oh));
        chk_eq("grant_tx_ready", 32'(TX_READY), 1);
        chk_eq("grant_busy", 32'(BUSY), 1);
        chk_eq("grant_tx_byte", 32'(SPI_TX_BYTE), 32'(tx_mem[v.rq][0]));
        chk_eq("grant_en_n_still_high", 32'(SPI_EN_N), 1);
        gnt_bad   = 0;
        watch_gnt = oh;
        watch_en  = 1;
        tick();
        chk_eq("run_en_n_low", 32'(SPI_EN_N), 0);
        wait_done(4000);
        REQ      = '0;
        watch_en = 0;
        chk_eq("tx_ready_count", n_txr - t0, n);
        chk_eq("rx_valid_count", n_rxv - r0, n);
        chk_eq("rx_queue_drained", exp_rx.size(), 0);
        chk_eq("gnt_held", gnt_bad, 0);
        tick();
        chk_eq("gnt_released", 32'(GNT), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_en_n"}, 32'(SPI_EN_N), 1);
        chk_eq({tag, "_gnt"}, 32'(GNT), 0);
        chk_eq({tag, "_busy"}, 32'(BUSY), 0);
        chk_eq({tag, "_sclk"}, 32'(SCLK_PULSE), 0);
        chk_eq({tag, "_pulses"}, 32'({TX_READY, RX_VALID, DONE, ERR}), 0);
        chk_eq({tag, "_rx_data"}, 32'(RX_DATA), 0);
        chk_eq({tag, "_tx_byte"}, 32'(SPI_TX_BYTE), 0);
    endtask

    initial begin
        int unsigned t0, r0, d0;
        bit          got;
        vecs[0] = '{rq: 0, len: 4'd2, b0: 8'hA5, step: 8'h97, preset: 1'b0};
        vecs[1] = '{rq: 1, len: 4'd3, b0: 8'h11, step: 8'h22, preset: 1'b0};
        vecs[2] = '{rq: 0, len: 4'd0, b0: 8'h01, step: 8'h1D, preset: 1'b0};
        vecs[3] = '{rq: 1, len: 4'd1, b0: 8'hF0, step: 8'h00, preset: 1'b1};
        vecs[4] = '{rq: 1, len: 4'd5, b0: 8'h80, step: 8'h01, preset: 1'b0};
        for (int r = 0; r < NREQ; r++) begin
            tx_idx[r] = 0;
            for (int i = 0; i < 32; i++) tx_mem[r][i] = '0;
        end

        RST = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        RST = 1'b0;

        // Both requesting after reset, two rounds: 0 then 1 each time.
        for (int round = 0; round < 2; round++) begin
            wait_idle();
            setup_req(0, 4'd2, 8'h12 + 8'(round), 8'h34, 1);
            setup_req(1, 4'd1, 8'hC7 - 8'(round), 8'h00, 1);
            exp_done.push_back({1'b0, 2'b01});
            exp_done.push_back({1'b0, 2'b10});
            REQ = 2'b11;
            wait_done(4000);
            REQ = 2'b10;
            wait_done(4000);
            REQ = 2'b00;
            chk_eq("rr_rx_drained", exp_rx.size(), 0);
        end

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Slave never advances: per-byte timeout.
        wait_idle();
        stall = 1;
        setup_req(0, 4'd1, 8'h55, 8'h00, 0);
        exp_done.push_back({1'b1, 2'b01});
        en_low_strobes = 0;
        t0  = n_txr;
        r0  = n_rxv;
        REQ = 2'b01;
        wait_done(4000);
        REQ = '0;
        chk_rng("timeout_strobes", en_low_strobes, TO - 1, TO);
        chk_eq("timeout_tx_ready", n_txr - t0, 1);
        chk_eq("timeout_rx_valid", n_rxv - r0, 0);
        tick();
        chk_eq("timeout_gnt_released", 32'(GNT), 0);
        stall = 0;

        // Reset after the first byte of a 3-byte transfer.
        wait_idle();
        setup_req(0, 4'd3, 8'h3A, 8'h11, 1);
        exp_done.push_back({1'b0, 2'b01});
        r0  = n_rxv;
        REQ = 2'b01;
        got = 0;
        for (int k = 0; k < 2000 && !got; k++) begin
            tick();
            if (n_rxv != r0) got = 1;
        end
        chk_eq("abort_first_rx", n_rxv - r0, 1);
        RST = 1'b1;
        REQ = '0;
        exp_rx.delete();
        exp_done.delete();
        tick();
        chk_reset_outputs("abort");
        tick();
        RST = 1'b0;
        d0  = n_done;
        repeat (300) tick();
        chk_eq("abort_no_done", n_done, d0);
        run_vec('{rq: 1, len: 4'd2, b0: 8'h6E, step: 8'h45, preset: 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
